ntt_loader: RTL and testbench



---
 rtl/ntt_pkg.sv | 20 ++
 rtl/ntt_coef_bank.sv | 28 ++
 rtl/ntt_loader.sv | 135 +++++++++++++
 tb/tb_ntt_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT types and constants: coefficient word, butterfly operand pair, loader FSM states.
// Pure declarations; no logic, no latency, no flow control.
package ntt_pkg;
    localparam int COEF_W = 64;
    localparam int N      = 32;
    localparam int LOG2N  = $clog2(N);
    localparam int HALF_N = N / 2;

    typedef logic [COEF_W-1:0] coef_t;

    typedef struct packed {
        coef_t b;
        coef_t a;
    } pair_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } ld_state_t;
endpackage

// File: rtl/ntt_coef_bank.sv
// One polynomial frame of coefficients: single write port, dual read at j and j+pN/2.
// Latency: write lands on the next edge; reads are combinational. No flow control of its own.
module ntt_coef_bank
    import ntt_pkg::*;
#(
    parameter int pCOEF_WIDTH = COEF_W,
    parameter int pN          = N
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(pN)-1:0]     wa,
    input  logic [pCOEF_WIDTH-1:0]    wd,
    input  logic [$clog2(pN)-2:0]     ra,
    output logic [pCOEF_WIDTH-1:0]    rd_lo,
    output logic [pCOEF_WIDTH-1:0]    rd_hi
);
    logic [pCOEF_WIDTH-1:0] mem [pN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // pN is a power of two, so the top address bit selects the upper half.
    assign rd_lo = mem[{1'b0, ra}];
    assign rd_hi = mem[{1'b1, ra}];
endmodule

// File: rtl/ntt_loader.sv
// Buffers a pN-coefficient frame and emits {x[j+pN/2], x[j]} pairs; NTT_LOADER_PINGPONG_EN adds a 2nd bank.
// Latency: pair 0 valid one edge after the final coefficient is accepted; then one pair per cycle.
// Backpressure: s_rdy low while no bank is empty; ld_d/ld_last held while ld_vld && !ld_rdy.
module ntt_loader
    import ntt_pkg::*;
#(
    parameter int pDATA_WIDTH = $bits(pair_t),
    parameter int pCOEF_WIDTH = COEF_W,
    parameter int pN          = N
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_vld,
    output logic                   s_rdy,
    input  logic [pCOEF_WIDTH-1:0] s_d,
    input  logic                   s_last,
    output logic                   ld_vld,
    input  logic                   ld_rdy,
    output logic [pDATA_WIDTH-1:0] ld_d,
    output logic                   ld_last,
    output logic                   err
);
    localparam int AW = $clog2(pN);
    localparam int JW = AW - 1;
    localparam logic [AW-1:0] WI_LAST = AW'(pN - 1);
    localparam logic [JW-1:0] J_LAST  = JW'(pN / 2 - 1);

    logic [AW-1:0]          wi;
    logic [JW-1:0]          rj;
    logic                   acc, frame_done, adv, fin, load, s_rdy_d;
    logic [pCOEF_WIDTH-1:0] src_lo, src_hi;

    assign acc        = s_vld && s_rdy;
    assign frame_done = acc && (wi == WI_LAST);
    assign adv        = !ld_vld || ld_rdy;
    assign fin        = ld_vld && ld_rdy && ld_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wi    <= '0;
            err   <= 1'b0;
            s_rdy <= 1'b0;
        end else begin
            err   <= acc && (s_last != (wi == WI_LAST));
            s_rdy <= s_rdy_d;
            if (acc) begin
                wi <= wi + AW'(1);
            end
        end
    end

`ifdef NTT_LOADER_PINGPONG_EN
    logic [1:0]             full, full_nxt;
    logic                   wb, rb, rb_nxt;
    logic [pCOEF_WIDTH-1:0] lo0, hi0, lo1, hi1;

    always_comb begin
        full_nxt = full;
        if (frame_done) full_nxt[wb] = 1'b1;
        if (fin)        full_nxt[rb] = 1'b0;
    end

    // On the final-pair handshake the read side already looks at the other bank,
    // so a waiting frame starts draining without a bubble.
    assign rb_nxt  = rb ^ fin;
    assign s_rdy_d = !full_nxt[wb ^ frame_done];
    assign load    = adv && full[rb_nxt];
    assign src_lo  = rb_nxt ? lo1 : lo0;
    assign src_hi  = rb_nxt ? hi1 : hi0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            full <= full_nxt;
            wb   <= wb ^ frame_done;
            rb   <= rb_nxt;
        end
    end

    ntt_coef_bank #(.pCOEF_WIDTH(pCOEF_WIDTH), .pN(pN)) u_bank0 (
        .clk(clk), .we(acc && !wb), .wa(wi), .wd(s_d), .ra(rj), .rd_lo(lo0), .rd_hi(hi0)
    );
    ntt_coef_bank #(.pCOEF_WIDTH(pCOEF_WIDTH), .pN(pN)) u_bank1 (
        .clk(clk), .we(acc && wb), .wa(wi), .wd(s_d), .ra(rj), .rd_lo(lo1), .rd_hi(hi1)
    );
`else
    ld_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:  if (frame_done) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fin)        state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    always_comb begin
        s_rdy_d = (state_nxt == ST_FILL);
        load    = adv && (state == ST_DRAIN) && !fin;
    end

    ntt_coef_bank #(.pCOEF_WIDTH(pCOEF_WIDTH), .pN(pN)) u_bank0 (
        .clk(clk), .we(acc), .wa(wi), .wd(s_d), .ra(rj), .rd_lo(src_lo), .rd_hi(src_hi)
    );
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_vld  <= 1'b0;
            ld_last <= 1'b0;
            ld_d    <= '0;
            rj      <= '0;
        end else if (load) begin
            ld_vld  <= 1'b1;
            ld_d    <= {src_hi, src_lo};
            ld_last <= (rj == J_LAST);
            rj      <= rj + JW'(1);
        end else if (ld_vld && ld_rdy) begin
            ld_vld  <= 1'b0;
            ld_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ntt_loader.sv
// Scoreboard bench for ntt_loader: frames are modelled as arrays, expected pairs queued per frame.
// A negedge monitor compares outputs, s_rdy occupancy, err pulses, latency and drain continuity.
module tb_ntt_loader;
    import ntt_pkg::*;

`ifdef NTT_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_vld, s_rdy, s_last;
    coef_t       s_d;
    logic        ld_vld, ld_rdy, ld_last, err;
    logic [2*COEF_W-1:0] ld_d;

    ntt_loader #(.pDATA_WIDTH(2*COEF_W), .pCOEF_WIDTH(COEF_W), .pN(N)) dut (
        .clk(clk), .rstn(rstn),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_d(s_d), .s_last(s_last),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_d(ld_d), .ld_last(ld_last), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        coef_t a;
        coef_t b;
        logic  last;
    } exp_t;

    exp_t  sb[$];
    coef_t frame_mem[N];
    int    checks = 0;
    int    errors = 0;
    int    mwi = 0, frames_buf = 0, lat_cnt = 0;
    logic  pending_err = 1'b0, armed = 1'b0, prev_hs_nonlast = 1'b0;
    int    rdy_mode = 0, ph = 0;
    bit    hs_m, was_last_m;
    pair_t p_m;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!rstn) begin
            chk("reset_ctrl", {s_rdy, ld_vld, ld_last, err}, 4'b0000);
            chk("reset_ld_d", ld_d, '0);
            sb.delete();
            mwi = 0; frames_buf = 0; lat_cnt = 0;
            pending_err = 1'b0; armed = 1'b0; prev_hs_nonlast = 1'b0;
        end else begin
            chk("s_rdy", s_rdy, armed && (frames_buf < NB));
            chk("err", err, pending_err);
            if (ld_vld) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_pair: ld_vld=1 with ld_d=%h but no pair expected at %0t", ld_d, $time);
                end else begin
                    p_m = ld_d;
                    chk("pair_a", p_m.a, sb[0].a);
                    chk("pair_b", p_m.b, sb[0].b);
                    chk("ld_last", ld_last, sb[0].last);
                end
            end
            if (prev_hs_nonlast) chk("no_bubble", ld_vld, 1'b1);
            if (lat_cnt == 2) begin
                chk("fill_latency_idle", ld_vld, 1'b0);
                lat_cnt = 1;
            end else if (lat_cnt == 1) begin
                chk("fill_latency_vld", ld_vld, 1'b1);
                lat_cnt = 0;
            end

            hs_m = ld_vld && ld_rdy;
            was_last_m = 1'b0;
            if (hs_m && sb.size() != 0) begin
                was_last_m = sb[0].last;
                void'(sb.pop_front());
                if (was_last_m) frames_buf--;
            end
            prev_hs_nonlast = hs_m && !was_last_m;

            pending_err = 1'b0;
            if (s_vld && s_rdy) begin
                pending_err = (s_last != (mwi == N - 1));
                frame_mem[mwi] = s_d;
                if (mwi == N - 1) begin
                    if (sb.size() == 0) lat_cnt = 2;
                    for (int j = 0; j < HALF_N; j++) begin
                        sb.push_back('{a: frame_mem[j], b: frame_mem[j + HALF_N], last: (j == HALF_N - 1)});
                    end
                    frames_buf++;
                    mwi = 0;
                end else begin
                    mwi++;
                end
            end
            armed = 1'b1;
        end
    end

    // Kernel-side ready: 0 = always, 1 = repeating 1,0,0,1, 2 = random.
    initial begin
        ld_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ld_rdy = 1'b1;
                1: begin ld_rdy = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
                default: ld_rdy = 1'($urandom_range(1));
            endcase
        end
    end

    task automatic send_beat(input coef_t d, input logic last);
        int  t = 0;
        bit  ok;
        s_vld = 1'b1; s_d = d; s_last = last;
        do begin
            @(negedge clk); ok = s_rdy;
            @(posedge clk); #1;
            t++;
        end while (!ok && t < 1000);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout: s_rdy stayed 0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic send_frame(input coef_t base, input bit rnd, input int last_pos,
                              input int nbeats, input bit gaps);
        coef_t d;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_vld = 1'b0; s_last = 1'b0;
                @(posedge clk); #1;
            end
            d = rnd ? {$urandom(), $urandom()} : base + coef_t'(i);
            send_beat(d, i == last_pos);
        end
        s_vld = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || ld_vld) && t < 3000) begin
            @(posedge clk); t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d pairs still pending, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1; s_vld = 1'b0; s_d = '0; s_last = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        send_frame(0, 0, N - 1, N, 0);            // basic frame
        wait_drain();
        rdy_mode = 1;
        send_frame(0, 1, N - 1, N, 0);            // backpressure 1,0,0,1
        wait_drain();
        rdy_mode = 0;
        send_frame(0, 0, 20, N, 0);               // early s_last
        wait_drain();
        send_frame(0, 0, N - 1, N, 0);            // back-to-back frames
        send_frame(100, 0, N - 1, N, 0);
        wait_drain();

        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            send_frame(0, 1, ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : N - 1, N, 1);
        end
        wait_drain();

        rdy_mode = 0;
        send_frame(0, 1, N - 1, 10, 0);           // reset mid-frame
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        send_frame(0, 0, N - 1, N, 0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached with %0d pairs pending", sb.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
